// File: rtl/selec_cnt_pkg.sv
// ============================================================================
// Module  : selec_cnt_pkg
// Brief   : Shared types and constants for the parametrised selector counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package selec_cnt_pkg;

  // Counter control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Count direction, captured at start
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Terminal behaviour, captured at start
  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/selec_cnt_presc.sv
// ============================================================================
// Module  : selec_cnt_presc
// Brief   : Prescaler tick generator; tick is high on the CE cycle where the
//           counter step is allowed (once every presc+1 CE cycles in RUN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module selec_cnt_presc #(
  parameter int unsigned PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  input  logic               clr,
  input  logic               run,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] pcnt_q;

  // >= keeps the divider from running away if presc is lowered mid-run
  assign tick = (pcnt_q >= presc);

  // Divider counter: cleared on start/stop, counts only while running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
    end else if (ce) begin
      if (clr) begin
        pcnt_q <= '0;
      end else if (run) begin
        pcnt_q <= tick ? '0 : pcnt_q + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/selec_contador_param.sv
// ============================================================================
// Module  : selec_contador_param
// Brief   : Start/stop counter with programmable limit, up/down direction,
//           wrap or one-shot mode, terminal-count and status flags.
//           Optional prescaler enabled by defining SELEC_CNT_PRESCALE_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module selec_contador_param
  import selec_cnt_pkg::*;
#(
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned PRESC_W = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               CE,
  input  logic               start,
  input  logic               stop,
  input  logic               mode_down,
  input  logic               one_shot,
  input  logic [WIDTH-1:0]   limit,
`ifdef SELEC_CNT_PRESCALE_EN
  input  logic [PRESC_W-1:0] presc,
`endif
  output logic [WIDTH-1:0]   cnt,
  output logic               tc,
  output logic               busy,
  output logic               done
);

  if (WIDTH < 1 || PRESC_W < 1) begin : g_param_check
    $error("selec_contador_param: WIDTH and PRESC_W must be at least 1");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic             dir_q, dir_d;
  logic             os_q, os_d;
  logic             tick_w;
  logic [WIDTH-1:0] term_w;
  logic [WIDTH-1:0] reload_w;
  logic             at_term_w;

`ifdef SELEC_CNT_PRESCALE_EN
  selec_cnt_presc #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk   (CLK),
    .rst_n (RESET),
    .ce    (CE),
    .clr   (start | stop),
    .run   (state_q == RUN),
    .presc (presc),
    .tick  (tick_w)
  );
`else
  assign tick_w = 1'b1;
`endif

  // Terminal is the limit when counting up and zero when counting down
  assign term_w    = (dir_q == DIR_DOWN) ? '0 : lim_q;
  assign reload_w  = (dir_q == DIR_DOWN) ? lim_q : '0;
  assign at_term_w = (cnt_q == term_w);

  // Next-state and count: stop beats start, start beats stepping
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    dir_d   = dir_q;
    os_d    = os_q;
    if (CE) begin
      if (stop) begin
        state_d = IDLE;
      end else if (start) begin
        state_d = RUN;
        lim_d   = limit;
        dir_d   = mode_down;
        os_d    = one_shot;
        cnt_d   = (mode_down == DIR_DOWN) ? limit : '0;
      end else if (state_q == RUN && tick_w) begin
        if (at_term_w) begin
          if (os_q == MODE_ONESHOT) begin
            state_d = DONE;
          end else begin
            cnt_d = reload_w;
          end
        end else if (dir_q == DIR_DOWN) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  // State, count and captured configuration registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lim_q   <= '0;
      dir_q   <= DIR_UP;
      os_q    <= MODE_WRAP;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
      dir_q   <= dir_d;
      os_q    <= os_d;
    end
  end

  assign cnt  = cnt_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign tc   = (state_q == RUN) && at_term_w && tick_w;

endmodule

`default_nettype wire

// File: tb/tb_selec_contador_param.sv
// ============================================================================
// Module  : tb_selec_contador_param
// Brief   : Directed self-checking bench for selec_contador_param (WIDTH=5).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_selec_contador_param;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       CE = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       mode_down = 1'b0;
  logic       one_shot = 1'b0;
  logic [4:0] limit = 5'd0;
  logic [4:0] cnt;
  logic       tc, busy, done;
`ifdef SELEC_CNT_PRESCALE_EN
  logic [3:0] presc = 4'd0;
`endif

  int checks = 0;
  int failures = 0;

  selec_contador_param #(.WIDTH(5), .PRESC_W(4)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .CE        (CE),
    .start     (start),
    .stop      (stop),
    .mode_down (mode_down),
    .one_shot  (one_shot),
    .limit     (limit),
`ifdef SELEC_CNT_PRESCALE_EN
    .presc     (presc),
`endif
    .cnt       (cnt),
    .tc        (tc),
    .busy      (busy),
    .done      (done)
  );

  always #5 CLK = ~CLK;

  // Advance one rising edge, then settle 1 time unit past it
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Pulse start for one edge with given configuration
  task automatic do_start(input logic dn, input logic os, input logic [4:0] lim);
    mode_down = dn; one_shot = os; limit = lim; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({cnt, tc, busy, done} !== {5'd0, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: cnt=%0d tc=%0b busy=%0b done=%0b, want 0 0 0 0", cnt, tc, busy, done);
    end
    step();
    RESET = 1'b1;
    step();
  endtask

  task automatic test_up_wrap();
    logic [4:0] ec;
    do_start(1'b0, 1'b0, 5'd5);
    checks++;
    if ({cnt, tc, busy} !== {5'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL up_wrap_load: cnt=%0d tc=%0b busy=%0b, want 0 0 1", cnt, tc, busy);
    end
    for (int i = 1; i <= 13; i++) begin
      step();
      ec = 5'(i % 6);
      checks++;
      if ({cnt, tc, busy, done} !== {ec, (ec == 5'd5), 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL up_wrap_step%0d: cnt=%0d tc=%0b busy=%0b done=%0b, want %0d %0b 1 0",
                 i, cnt, tc, busy, done, ec, (ec == 5'd5));
      end
    end
  endtask

  task automatic test_down_oneshot();
    logic [4:0] exp_seq [4] = '{5'd3, 5'd2, 5'd1, 5'd0};
    do_stop();
    do_start(1'b1, 1'b1, 5'd3);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      checks++;
      if ({cnt, tc, busy, done} !== {exp_seq[i], (i == 3), 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL down_os_run%0d: cnt=%0d tc=%0b busy=%0b done=%0b, want %0d %0b 1 0",
                 i, cnt, tc, busy, done, exp_seq[i], (i == 3));
      end
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({cnt, tc, busy, done} !== {5'd0, 1'b0, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL down_os_done%0d: cnt=%0d tc=%0b busy=%0b done=%0b, want 0 0 0 1",
                 i, cnt, tc, busy, done);
      end
    end
    do_start(1'b1, 1'b1, 5'd3);
    checks++;
    if ({cnt, busy, done} !== {5'd3, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL down_os_restart: cnt=%0d busy=%0b done=%0b, want 3 1 0", cnt, busy, done);
    end
  endtask

  task automatic test_mid_run();
    do_stop();
    do_start(1'b0, 1'b0, 5'd7);
    step(); step();
    do_stop();
    checks++;
    if ({cnt, busy, done} !== {5'd2, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL stop_holds: cnt=%0d busy=%0b done=%0b, want 2 0 0", cnt, busy, done);
    end
    step();
    checks++;
    if ({cnt, busy} !== {5'd2, 1'b0}) begin
      failures++;
      $display("FAIL idle_holds: cnt=%0d busy=%0b, want 2 0", cnt, busy);
    end
    start = 1'b1; stop = 1'b1; mode_down = 1'b1; limit = 5'd9;
    step();
    start = 1'b0; stop = 1'b0;
    checks++;
    if ({cnt, busy} !== {5'd2, 1'b0}) begin
      failures++;
      $display("FAIL start_stop_same: cnt=%0d busy=%0b, want 2 0", cnt, busy);
    end
    do_start(1'b0, 1'b0, 5'd7);
    step(); step(); step(); step();
    checks++;
    if (cnt !== 5'd4) begin
      failures++;
      $display("FAIL run_to_4: cnt=%0d, want 4", cnt);
    end
    do_start(1'b0, 1'b0, 5'd7);
    checks++;
    if ({cnt, busy} !== {5'd0, 1'b1}) begin
      failures++;
      $display("FAIL restart_in_run: cnt=%0d busy=%0b, want 0 1", cnt, busy);
    end
  endtask

  task automatic test_ce_and_max();
    // Configuration changes without start must be ignored
    limit = 5'd1; mode_down = 1'b1; one_shot = 1'b1;
    for (int i = 0; i < 7; i++) step();
    checks++;
    if ({cnt, tc, busy} !== {5'd7, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL reach_7: cnt=%0d tc=%0b busy=%0b, want 7 1 1", cnt, tc, busy);
    end
    CE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({cnt, tc, busy, done} !== {5'd7, 1'b1, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL ce_hold%0d: cnt=%0d tc=%0b busy=%0b done=%0b, want 7 1 1 0", i, cnt, tc, busy, done);
      end
    end
    CE = 1'b1;
    step();
    checks++;
    if ({cnt, tc, busy} !== {5'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL ce_resume_wrap: cnt=%0d tc=%0b busy=%0b, want 0 0 1", cnt, tc, busy);
    end
    do_start(1'b0, 1'b0, 5'd31);
    for (int i = 0; i < 31; i++) step();
    checks++;
    if ({cnt, tc} !== {5'd31, 1'b1}) begin
      failures++;
      $display("FAIL max_term: cnt=%0d tc=%0b, want 31 1", cnt, tc);
    end
    step();
    checks++;
    if ({cnt, tc, busy} !== {5'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL max_wrap: cnt=%0d tc=%0b busy=%0b, want 0 0 1", cnt, tc, busy);
    end
  endtask

  task automatic test_limit_zero();
    do_start(1'b0, 1'b0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      checks++;
      if ({cnt, tc, busy} !== {5'd0, 1'b1, 1'b1}) begin
        failures++;
        $display("FAIL lim0_wrap%0d: cnt=%0d tc=%0b busy=%0b, want 0 1 1", i, cnt, tc, busy);
      end
    end
    do_start(1'b0, 1'b1, 5'd0);
    checks++;
    if ({tc, busy, done} !== {1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL lim0_os_k: tc=%0b busy=%0b done=%0b, want 1 1 0", tc, busy, done);
    end
    step();
    checks++;
    if ({cnt, tc, busy, done} !== {5'd0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL lim0_os_k1: cnt=%0d tc=%0b busy=%0b done=%0b, want 0 0 0 1", cnt, tc, busy, done);
    end
  endtask

  task automatic test_async_reset();
    do_start(1'b0, 1'b0, 5'd20);
    for (int i = 0; i < 6; i++) step();
    #2;
    RESET = 1'b0;
    #1;
    checks++;
    if ({cnt, tc, busy, done} !== {5'd0, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset_now: cnt=%0d tc=%0b busy=%0b done=%0b, want 0 0 0 0", cnt, tc, busy, done);
    end
    step(); step();
    checks++;
    if ({cnt, busy} !== {5'd0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset_hold: cnt=%0d busy=%0b, want 0 0", cnt, busy);
    end
    #2;
    RESET = 1'b1;
    step();
    checks++;
    if ({cnt, busy} !== {5'd0, 1'b0}) begin
      failures++;
      $display("FAIL after_reset_idle: cnt=%0d busy=%0b, want 0 0", cnt, busy);
    end
  endtask

`ifdef SELEC_CNT_PRESCALE_EN
  task automatic test_presc();
    logic [4:0] ec;
    logic       et;
    presc = 4'd2;
    do_start(1'b0, 1'b0, 5'd2);
    for (int i = 1; i <= 12; i++) begin
      step();
      ec = 5'((i / 3) % 3);
      et = (ec == 5'd2) && ((i % 3) == 2);
      checks++;
      if ({cnt, tc, busy} !== {ec, et, 1'b1}) begin
        failures++;
        $display("FAIL presc_step%0d: cnt=%0d tc=%0b busy=%0b, want %0d %0b 1", i, cnt, tc, busy, ec, et);
      end
    end
    presc = 4'd0;
    do_stop();
  endtask
`endif

  initial begin
    test_reset();
    test_up_wrap();
    test_down_oneshot();
    test_mid_run();
    test_ce_and_max();
    test_limit_zero();
`ifdef SELEC_CNT_PRESCALE_EN
    test_presc();
`endif
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
